multi_player_score_ctrl: RTL and testbench

- Parametrised successor to the two-tank score logic.
- Tracks scores for N_PLAYERS tanks and N_BUFFS score-buff types.
- Handles edge-detected hit, buff, shield-buff and bonus events per player, with hit cooldown and timed immunity.
- Detects win/lose through a game-state FSM and drives per-player BCD score digits to the VGA score display.

---
 rtl/score_pkg.sv | 33 +++
 rtl/player_score_unit.sv | 112 +++++++++++
 rtl/multi_player_score_ctrl.sv | 102 ++++++++++
 tb/tb_multi_player_score_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types, constants and score arithmetic helpers for the multi-player score controller.
package score_pkg;

  localparam int SCORE_MAX = 99;
  localparam logic signed [8:0] SCORE_MAX_S = 9'sd99;

  typedef logic [6:0] score_t;

  typedef enum logic {
    PLAYING = 1'b0,
    OVER    = 1'b1
  } game_state_t;

  // Points awarded by each score-buff type (3, 2, 4 for buffs 0..2).
  function automatic int buff_val(input int b);
    case (b)
      0:       return 3;
      1:       return 2;
      2:       return 4;
      default: return 0;
    endcase
  endfunction

  function automatic score_t clamp_score(input logic signed [8:0] v);
    if (v < 0)
      return '0;
    else if (v > SCORE_MAX_S)
      return score_t'(SCORE_MAX);
    else
      return v[6:0];
  endfunction

endpackage

// File: rtl/player_score_unit.sv
// One player's event edge detection, hit/immunity timers, buff cooldown, score register and BCD split.
module player_score_unit
  import score_pkg::*;
#(
  parameter int N_BUFFS        = 3,
  parameter int START_SCORE    = 25,
  parameter int HIT_SCORE      = 4,
  parameter int BONUS_SCORE    = 10,
  parameter int HIT_COOLDOWN_S = 2,
  parameter int IMMUNITY_S     = 10
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               en_i,
  input  logic               one_sec_i,
  input  logic               hit_i,
  input  logic [N_BUFFS-1:0] buff_i,
  input  logic               shieldBuff_i,
  input  logic               bonus_i,
  output score_t             score_o,
  output logic               shield_o,
  output logic [3:0]         tens_o,
  output logic [3:0]         ones_o
);

  localparam int TMAX  = (HIT_COOLDOWN_S > IMMUNITY_S) ? HIT_COOLDOWN_S : IMMUNITY_S;
  localparam int CNT_W = (TMAX < 1) ? 1 : $clog2(TMAX + 1);
  localparam logic [CNT_W-1:0] HIT_LOAD = CNT_W'(HIT_COOLDOWN_S);
  localparam logic [CNT_W-1:0] IMM_LOAD = CNT_W'(IMMUNITY_S);
  localparam logic signed [8:0] HIT_D   = 9'(HIT_SCORE);
  localparam logic signed [8:0] BONUS_D = 9'(BONUS_SCORE);

  logic               hit_q, shb_q, bonus_q;
  logic [N_BUFFS-1:0] buff_q;
  logic [CNT_W-1:0]   hitCnt_q, hitCnt_d;
  logic [CNT_W-1:0]   immCnt_q, immCnt_d;
  logic               buffCd_q, buffCd_d;
  logic               shield_q, shield_d;
  score_t             score_q, score_d;

  logic               hit_acc, bonus_acc, imm_load;
  logic [N_BUFFS-1:0] buff_acc;
  logic signed [8:0]  delta;

  always_comb begin
    hit_acc   = en_i & hit_i & ~hit_q & ~shield_q;
    bonus_acc = en_i & bonus_i & ~bonus_q;
    imm_load  = en_i & shieldBuff_i & ~shb_q & (immCnt_q == '0);
    buff_acc  = (en_i && !buffCd_q) ? (buff_i & ~buff_q) : '0;

    // Every accepted event contributes; none masks another.
    delta = '0;
    if (hit_acc)
      delta = delta - HIT_D;
    for (int b = 0; b < N_BUFFS; b++)
      if (buff_acc[b])
        delta = delta + 9'(buff_val(b));
    if (bonus_acc)
      delta = delta + BONUS_D;

    score_d  = score_q;
    hitCnt_d = hitCnt_q;
    immCnt_d = immCnt_q;
    buffCd_d = buffCd_q;
    if (en_i) begin
      score_d = clamp_score($signed({2'b00, score_q}) + delta);
      if (hit_acc)
        hitCnt_d = HIT_LOAD;
      else if (one_sec_i && hitCnt_q != '0)
        hitCnt_d = hitCnt_q - 1'b1;
      if (imm_load)
        immCnt_d = IMM_LOAD;
      else if (one_sec_i && immCnt_q != '0)
        immCnt_d = immCnt_q - 1'b1;
      if (|buff_acc)
        buffCd_d = 1'b1;
      else if (one_sec_i)
        buffCd_d = 1'b0;
    end
    shield_d = (hitCnt_d != '0) | (immCnt_d != '0);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit_q    <= 1'b0;
      shb_q    <= 1'b0;
      bonus_q  <= 1'b0;
      buff_q   <= '0;
      hitCnt_q <= '0;
      immCnt_q <= '0;
      buffCd_q <= 1'b0;
      shield_q <= 1'b0;
      score_q  <= score_t'(START_SCORE);
    end else begin
      hit_q    <= hit_i;
      shb_q    <= shieldBuff_i;
      bonus_q  <= bonus_i;
      buff_q   <= buff_i;
      hitCnt_q <= hitCnt_d;
      immCnt_q <= immCnt_d;
      buffCd_q <= buffCd_d;
      shield_q <= shield_d;
      score_q  <= score_d;
    end
  end

  assign score_o  = score_q;
  assign shield_o = shield_q;
  assign tens_o   = 4'(score_q / 7'd10);
  assign ones_o   = 4'(score_q % 7'd10);

endmodule

// File: rtl/multi_player_score_ctrl.sv
// N-player score controller: per-player score units plus the win/lose game-state FSM.
module multi_player_score_ctrl
  import score_pkg::*;
#(
  parameter int N_PLAYERS      = 2,
  parameter int N_BUFFS        = 3,
  parameter int START_SCORE    = 25,
  parameter int WIN_SCORE      = 61,
  parameter int LOSE_SCORE     = 3,
  parameter int HIT_SCORE      = 4,
  parameter int BONUS_SCORE    = 10,
  parameter int HIT_COOLDOWN_S = 2,
  parameter int IMMUNITY_S     = 10
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         countEn,
  input  logic                         one_sec,
  input  logic [N_PLAYERS-1:0]         hit,
  input  logic [N_PLAYERS*N_BUFFS-1:0] buffHit,
  input  logic [N_PLAYERS-1:0]         shieldBuff,
  input  logic [N_PLAYERS-1:0]         bonus,
  output logic [4*N_PLAYERS-1:0]       digitTens,
  output logic [4*N_PLAYERS-1:0]       digitOnes,
  output logic [N_PLAYERS-1:0]         win,
  output logic [N_PLAYERS-1:0]         lose,
  output logic [N_PLAYERS-1:0]         shield,
  output logic                         gameOver
);

  game_state_t            state_q, state_d;
  logic [N_PLAYERS-1:0]   win_q, win_d, lose_q, lose_d;
  logic [N_PLAYERS-1:0]   win_hit, lose_hit;
  score_t                 scores [N_PLAYERS];
  logic                   en;

  assign en = countEn & (state_q == PLAYING);

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_player
    player_score_unit #(
      .N_BUFFS       (N_BUFFS),
      .START_SCORE   (START_SCORE),
      .HIT_SCORE     (HIT_SCORE),
      .BONUS_SCORE   (BONUS_SCORE),
      .HIT_COOLDOWN_S(HIT_COOLDOWN_S),
      .IMMUNITY_S    (IMMUNITY_S)
    ) u_unit (
      .clk         (clk),
      .resetN      (resetN),
      .en_i        (en),
      .one_sec_i   (one_sec),
      .hit_i       (hit[g]),
      .buff_i      (buffHit[g*N_BUFFS +: N_BUFFS]),
      .shieldBuff_i(shieldBuff[g]),
      .bonus_i     (bonus[g]),
      .score_o     (scores[g]),
      .shield_o    (shield[g]),
      .tens_o      (digitTens[4*g +: 4]),
      .ones_o      (digitOnes[4*g +: 4])
    );

    assign win_hit[g]  = (scores[g] >= score_t'(WIN_SCORE));
    assign lose_hit[g] = (scores[g] <= score_t'(LOSE_SCORE));
  end

  // Win outranks lose when both are seen in the same cycle.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    lose_d  = lose_q;
    case (state_q)
      PLAYING: begin
        if (|win_hit) begin
          win_d   = win_hit;
          state_d = OVER;
        end else if (|lose_hit) begin
          lose_d  = lose_hit;
          state_d = OVER;
        end
      end
      OVER:    state_d = OVER;
      default: state_d = PLAYING;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= PLAYING;
      win_q   <= '0;
      lose_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
    end
  end

  assign win      = win_q;
  assign lose     = lose_q;
  assign gameOver = (state_q == OVER);

endmodule

// File: tb/tb_multi_player_score_ctrl.sv
// Directed bench for multi_player_score_ctrl with two players and default parameters.
module tb_multi_player_score_ctrl;

  logic       clk = 1'b0;
  logic       resetN, countEn, one_sec;
  logic [1:0] hit, shieldBuff, bonus;
  logic [5:0] buffHit;
  logic [7:0] digitTens, digitOnes;
  logic [1:0] win, lose, shield;
  logic       gameOver;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multi_player_score_ctrl dut (
    .clk       (clk),
    .resetN    (resetN),
    .countEn   (countEn),
    .one_sec   (one_sec),
    .hit       (hit),
    .buffHit   (buffHit),
    .shieldBuff(shieldBuff),
    .bonus     (bonus),
    .digitTens (digitTens),
    .digitOnes (digitOnes),
    .win       (win),
    .lose      (lose),
    .shield    (shield),
    .gameOver  (gameOver)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] score(input int p);
    return digitTens[4*p +: 4] * 10 + digitOnes[4*p +: 4];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sec();
    one_sec = 1'b1;
    tick();
    one_sec = 1'b0;
  endtask

  task automatic pulse_hit(input logic [1:0] m);
    hit = m; tick(); hit = '0; tick();
  endtask

  task automatic pulse_bonus(input logic [1:0] m);
    bonus = m; tick(); bonus = '0; tick();
  endtask

  task automatic pulse_buff(input logic [5:0] m);
    buffHit = m; tick(); buffHit = '0; tick();
  endtask

  task automatic do_reset();
    hit = '0; shieldBuff = '0; bonus = '0; buffHit = '0; one_sec = 1'b0;
    resetN = 1'b0;
    tick(); tick();
    resetN = 1'b1;
    countEn = 1'b1;
  endtask

  initial begin
    resetN = 1'b0; countEn = 1'b0; one_sec = 1'b0;
    hit = '0; shieldBuff = '0; bonus = '0; buffHit = '0;
    tick(); tick();

    // Reset state
    chk("rst_score0", score(0), 25);
    chk("rst_score1", score(1), 25);
    chk("rst_win", win, 0);
    chk("rst_lose", lose, 0);
    chk("rst_shield", shield, 0);
    chk("rst_gameover", gameOver, 0);
    resetN = 1'b1;
    countEn = 1'b1;

    // Held hit scores once, then post-hit cooldown
    hit = 2'b01; tick();
    chk("hit_score0", score(0), 21);
    chk("hit_shield0", shield[0], 1);
    tick(); tick(); hit = '0; tick();
    chk("hit_level_once", score(0), 21);
    pulse_hit(2'b01);
    chk("hit_during_cd", score(0), 21);
    sec();
    chk("cd_after_1s", shield[0], 1);
    sec();
    chk("cd_after_2s", shield[0], 0);

    // Same-cycle buffs + bonus, then buff cooldown
    buffHit = 6'b101_000; bonus = 2'b10; tick();
    chk("multi_evt_score1", score(1), 42);
    buffHit = '0; bonus = '0; tick();
    pulse_buff(6'b001_000);
    chk("buff_cd_ignored", score(1), 42);
    sec();
    pulse_buff(6'b001_000);
    chk("buff_after_sec", score(1), 45);

    // Immunity: hits ignored for 10 s, re-trigger does not extend
    do_reset();
    shieldBuff = 2'b01; tick(); shieldBuff = '0; tick();
    chk("imm_shield_on", shield[0], 1);
    for (int k = 0; k < 10; k++) begin
      if (k == 5) begin
        shieldBuff = 2'b01; tick(); shieldBuff = '0;
      end
      pulse_hit(2'b01);
      chk($sformatf("imm_score_k%0d", k), score(0), 25);
      chk($sformatf("imm_shield_k%0d", k), shield[0], 1);
      sec();
    end
    chk("imm_expired", shield[0], 0);
    pulse_hit(2'b01);
    chk("hit_after_imm", score(0), 21);
    sec(); sec();
    hit = 2'b01; shieldBuff = 2'b01; tick();
    hit = '0; shieldBuff = '0;
    chk("hit_plus_shb_score", score(0), 17);
    tick();
    sec(); sec(); sec();
    chk("hit_plus_shb_imm", shield[0], 1);

    // Single winner
    do_reset();
    pulse_bonus(2'b10); pulse_bonus(2'b10); pulse_bonus(2'b10);
    pulse_buff(6'b001_000);
    chk("p1_at_58", score(1), 58);
    sec();
    buffHit = 6'b100_000; tick();
    chk("p1_at_62", score(1), 62);
    chk("win_not_yet", gameOver, 0);
    buffHit = '0; tick();
    chk("win1_flag", win, 2'b10);
    chk("win1_gameover", gameOver, 1);
    chk("win1_lose", lose, 0);
    chk("win1_tens", digitTens[7:4], 6);
    chk("win1_ones", digitOnes[7:4], 2);
    pulse_bonus(2'b10);
    pulse_hit(2'b01);
    sec();
    chk("over_hold_s1", score(1), 62);
    chk("over_hold_s0", score(0), 25);
    chk("over_hold_win", win, 2'b10);
    chk("over_hold_shield", shield, 0);

    // Both win on the same cycle
    do_reset();
    pulse_bonus(2'b11); pulse_bonus(2'b11); pulse_bonus(2'b11);
    pulse_buff(6'b001_001);
    sec();
    pulse_buff(6'b001_001);
    chk("dual_s0", score(0), 61);
    chk("dual_s1", score(1), 61);
    chk("dual_win", win, 2'b11);
    chk("dual_lose", lose, 0);

    // Lose at the LOSE_SCORE boundary
    do_reset();
    pulse_buff(6'b000_010);
    chk("lose_start", score(0), 27);
    for (int k = 0; k < 5; k++) begin
      pulse_hit(2'b01);
      sec(); sec();
    end
    chk("lose_at_7", score(0), 7);
    chk("lose_not_yet", lose, 0);
    hit = 2'b01; tick(); hit = '0;
    chk("lose_at_3", score(0), 3);
    tick();
    chk("lose_flag", lose, 2'b01);
    chk("lose_win", win, 0);
    chk("lose_gameover", gameOver, 1);

    // countEn low while hit rises: no score after enabling
    do_reset();
    countEn = 1'b0;
    hit = 2'b10; tick(); tick();
    chk("en_off_score1", score(1), 25);
    countEn = 1'b1; tick(); tick();
    chk("en_on_level", score(1), 25);
    hit = '0; tick();

    // Asynchronous reset mid-cooldown
    pulse_hit(2'b01);
    chk("pre_rst_score0", score(0), 21);
    chk("pre_rst_shield", shield[0], 1);
    #2 resetN = 1'b0;
    #1;
    chk("async_rst_shield", shield, 0);
    chk("async_rst_score0", score(0), 25);
    chk("async_rst_score1", score(1), 25);
    tick();
    resetN = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
